spectrum_band_analyzer: RTL
===========================

SPECTRUM_BAND_ANALYZER -- requirements
Module: spectrum_band_analyzer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, width of input magnitude and output levels.
REQ-002 SHALL have parameter FFT_SIZE, default 1024, bins per frame (power of 2, >= 4).
REQ-003 SHALL have parameter BINS_PER_BAND, default 64, bins averaged per band (power of 2, >= 2, <= FFT_SIZE).
REQ-004 SHALL derive localparams NUM_BANDS = FFT_SIZE/BINS_PER_BAND, BIN_W = log2(FFT_SIZE) and BAND_W = max(1, log2(NUM_BANDS)).
REQ-005 Port list, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  one magnitude bin present this cycle.
- i_magnitude  in  DATA_WIDTH  unsigned bin magnitude.
- o_band_valid  out  1  band result held.
- i_band_ready  in  1  downstream accepts band result.
- o_band_index  out  BAND_W  band number, 0 = lowest bins.
- o_band_level  out  DATA_WIDTH  mean magnitude of band.
- o_peak_valid  out  1  one-cycle pulse, frame peak available.
- o_peak_bin  out  BIN_W  bin index of frame peak.
- o_peak_mag  out  DATA_WIDTH  frame peak magnitude.
- o_overflow  out  1  sticky, band result dropped.

Function
REQ-006 Input stream SHALL have no backpressure; every cycle with i_valid=1 consumes one bin; i_valid=0 cycles are gaps and SHALL change no state.
REQ-007 A bin counter (BIN_W bits) SHALL increment per accepted bin and wrap from FFT_SIZE-1 to 0; bin 0 after wrap starts a new frame.
REQ-008 Band accumulator width SHALL be DATA_WIDTH+log2(BINS_PER_BAND); no overflow possible.
REQ-009 On the bin where bin_count[log2(BINS_PER_BAND)-1:0] is all ones, the band completes: level = (accumulator + that bin) >> log2(BINS_PER_BAND), truncated; accumulator restarts at 0 for the next bin.
REQ-010 Completed band SHALL appear in the output register on the next clock edge (latency 1 cycle after last bin), with o_band_index = bin_count >> log2(BINS_PER_BAND).
REQ-011 Output handshake: o_band_valid stays 1 and o_band_index/o_band_level stay stable until a cycle with o_band_valid=1 and i_band_ready=1; o_band_valid then drops unless a new band loads that same edge.
REQ-012 New band completing while register is empty, or in the same cycle the held band is accepted, SHALL load with no loss.
REQ-013 New band completing while held band is not accepted (o_band_valid=1, i_band_ready=0) SHALL be dropped, held band kept unchanged, o_overflow set to 1 and held until reset.
REQ-014 Peak tracker SHALL compare each bin against the running max; update only on strictly greater; ties keep the lower bin index; bin 0 of a frame loads unconditionally.
REQ-015 On the frame's last bin (bin FFT_SIZE-1), o_peak_valid SHALL pulse 1 for exactly one cycle on the next edge, with o_peak_bin/o_peak_mag including that last bin; the values hold until the next pulse.
REQ-016 o_peak_valid pulse and a band load MAY occur on the same edge; both SHALL be correct.
REQ-017 Internal states SHALL be ACCUM (collecting bins) and HOLD (band register full), with ACCUM->HOLD on band load and HOLD->ACCUM on accept without reload; bin accumulation SHALL continue in both states.

Reset
REQ-018 On reset: bin counter, accumulator and running max = 0; o_band_valid=0, o_peak_valid=0, o_overflow=0, o_band_index=0, o_band_level=0, o_peak_bin=0, o_peak_mag=0.
REQ-019 Reset mid-frame SHALL discard the partial frame and held band; the first i_valid after reset is bin 0.
REQ-020 reset asserted with i_valid=1 SHALL ignore that bin.

Verification (bench params FFT_SIZE=16, BINS_PER_BAND=4, DATA_WIDTH=8)
REQ-021 16 bins of constant 100, i_band_ready=1 -> four band outputs of index 0..3, level 100 each, each 1 cycle after bins 3/7/11/15; o_peak_valid pulse with bin 0, mag 100 (tie rule).
REQ-022 Bins 0..15 = 10,20,...,160 (last 160), i_band_ready=1 -> levels 25,65,105,145; peak bin 15, mag 160, pulse 1 cycle after bin 15.
REQ-023 Bins 5 and 9 = 255, rest 0, random i_valid gaps -> results identical to gap-free run; peak bin 5, mag 255; band 1 level 63, band 2 level 63.
REQ-024 i_band_ready=0 throughout a frame -> band 0 held (index 0) for whole frame, o_overflow=1 one cycle after bin 7, stays 1; raising ready then drops o_band_valid next edge.
REQ-025 Ready=1 exactly on the cycle band 1 completes -> band 0 accepted, band 1 loads same edge, o_overflow stays 0.
REQ-026 Reset after bin 6, then 16 bins of 50 -> no stale output; bands 0..3 level 50, peak bin 0, mag 50.

Source files
------------

// File: rtl/spectrum_band_analyzer.sv
// spectrum_band_analyzer
// Consumes a stream of unsigned FFT bin magnitudes (one bin per i_valid cycle,
// no backpressure) and produces:
//   - one averaged level per band of BINS_PER_BAND consecutive bins, presented
//     through a single-entry valid/ready output register;
//   - the frame peak (bin index and magnitude), pulsed once per frame.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   i_valid          one magnitude bin present this cycle
//   i_magnitude      unsigned bin magnitude
//   o_band_valid     band result held in the output register
//   i_band_ready     downstream accepts the held band result
//   o_band_index     band number, 0 = lowest bins
//   o_band_level     mean magnitude of the band (truncated)
//   o_peak_valid     one-cycle pulse, frame peak available
//   o_peak_bin       bin index of the frame peak
//   o_peak_mag       frame peak magnitude
//   o_overflow       sticky, a completed band was dropped
//
// State | meaning
// ACCUM | band output register empty, bins being collected
// HOLD  | band output register full, waiting for i_band_ready
module spectrum_band_analyzer #(
    parameter int DATA_WIDTH    = 24,
    parameter int FFT_SIZE      = 1024,
    parameter int BINS_PER_BAND = 64
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        i_valid,
    input  logic [DATA_WIDTH-1:0]                       i_magnitude,
    output logic                                        o_band_valid,
    input  logic                                        i_band_ready,
    output logic [((FFT_SIZE/BINS_PER_BAND) > 1 ? $clog2(FFT_SIZE/BINS_PER_BAND) : 1)-1:0] o_band_index,
    output logic [DATA_WIDTH-1:0]                       o_band_level,
    output logic                                        o_peak_valid,
    output logic [$clog2(FFT_SIZE)-1:0]                 o_peak_bin,
    output logic [DATA_WIDTH-1:0]                       o_peak_mag,
    output logic                                        o_overflow
);

    localparam int NUM_BANDS = FFT_SIZE / BINS_PER_BAND;
    localparam int BIN_W     = $clog2(FFT_SIZE);
    localparam int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int SHIFT     = $clog2(BINS_PER_BAND);
    localparam int ACC_W     = DATA_WIDTH + SHIFT;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [BIN_W-1:0]        bin_count;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        band_sum;
    logic [BAND_W-1:0]       band_idx;
    logic                    band_done;
    logic                    frame_start;
    logic                    frame_last;
    logic [DATA_WIDTH-1:0]   run_max;
    logic [BIN_W-1:0]        run_bin;
    logic                    take_new;
    logic [DATA_WIDTH-1:0]   max_nxt;
    logic [BIN_W-1:0]        bin_nxt;
    logic                    load_band;
    logic                    drop_band;

    assign band_sum    = acc + ACC_W'(i_magnitude);
    assign band_done   = i_valid && (&bin_count[SHIFT-1:0]);
    assign frame_start = (bin_count == '0);
    assign frame_last  = &bin_count;

    // Band number is the upper bits of the bin counter; a single-band frame
    // has no such bits and always reports band 0.
    generate
        if (NUM_BANDS > 1) begin : g_band_idx
            assign band_idx = bin_count[BIN_W-1:SHIFT];
        end else begin : g_band_idx_one
            assign band_idx = '0;
        end
    endgenerate

    // Bin 0 reloads the running max so a frame never inherits the previous
    // frame's peak; strict compare keeps the lowest bin on ties.
    assign take_new = frame_start || (i_magnitude > run_max);
    assign max_nxt  = take_new ? i_magnitude : run_max;
    assign bin_nxt  = take_new ? bin_count   : run_bin;

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_count <= '0;
            acc       <= '0;
            run_max   <= '0;
            run_bin   <= '0;
        end else if (i_valid) begin
            bin_count <= bin_count + 1'b1;
            acc       <= band_done ? '0 : band_sum;
            run_max   <= max_nxt;
            run_bin   <= bin_nxt;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (band_done) state_nxt = HOLD;
            HOLD:  if (i_band_ready && !band_done) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // FSM: outputs. A band completing while the held one is accepted the
    // same cycle replaces it with no gap.
    always_comb begin
        load_band    = 1'b0;
        drop_band    = 1'b0;
        o_band_valid = (state == HOLD);
        if (band_done) begin
            if (state == ACCUM || i_band_ready) begin
                load_band = 1'b1;
            end else begin
                drop_band = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_band_index <= '0;
            o_band_level <= '0;
            o_overflow   <= 1'b0;
        end else begin
            if (load_band) begin
                o_band_index <= band_idx;
                o_band_level <= band_sum[ACC_W-1:SHIFT];
            end
            if (drop_band) begin
                o_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_peak_valid <= 1'b0;
            o_peak_bin   <= '0;
            o_peak_mag   <= '0;
        end else begin
            o_peak_valid <= i_valid && frame_last;
            if (i_valid && frame_last) begin
                o_peak_bin <= bin_nxt;
                o_peak_mag <= max_nxt;
            end
        end
    end

endmodule
